// File: rtl/harris_pkg.sv
// harris_pkg: state encoding, default geometry and widths shared by the Harris frame controller.
package harris_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_FLUSH = 2'd2;
    localparam state_t S_DONE  = 2'd3;
    localparam int DEF_IMG_W    = 640;
    localparam int DEF_IMG_H    = 480;
    localparam int DEF_PIPE_LAT = 3;
    localparam int CC_W         = 20;
    function automatic int cnt_w_for(input int w, input int h);
        return $clog2((w > h ? w : h) + 1);
    endfunction
    localparam int DEF_CNT_W = cnt_w_for(DEF_IMG_W, DEF_IMG_H);
endpackage

// File: rtl/harris_frame_ctrl_if.sv
// harris_frame_ctrl_if: pixel stream, datapath score and frame status bundle of the Harris controller.
interface harris_frame_ctrl_if import harris_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic             start;
    logic             pix_valid;
    logic             pix_ready;
    logic             pipe_en;
    logic [7:0]       harris_in;
    logic [7:0]       thresh;
    logic             out_valid;
    logic [CNT_W-1:0] out_x;
    logic [CNT_W-1:0] out_y;
    logic             border;
    logic             busy;
    logic             frame_done;
    logic [CC_W-1:0]  corner_count;
    modport master (
        output start, pix_valid, harris_in, thresh,
        input  pix_ready, pipe_en, out_valid, out_x, out_y, border, busy, frame_done, corner_count
    );
    modport slave (
        input  start, pix_valid, harris_in, thresh,
        output pix_ready, pipe_en, out_valid, out_x, out_y, border, busy, frame_done, corner_count
    );
endinterface

// File: rtl/harris_valid_delay.sv
// harris_valid_delay: LAT-deep shift line for {valid, x, y, border}; payload only moves with a valid
// entry, so the output payload holds the last valid centre while valid is low.
module harris_valid_delay #(
    parameter int LAT   = 3,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] in_x,
    input  logic [CNT_W-1:0] in_y,
    input  logic             in_border,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_x,
    output logic [CNT_W-1:0] out_y,
    output logic             out_border
);
    localparam int DW = 2 * CNT_W + 1;
    logic [LAT-1:0] vld;
    logic [DW-1:0]  dat [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= {in_x, in_y, in_border};
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end
    assign out_valid = vld[LAT-1];
    assign {out_x, out_y, out_border} = dat[LAT-1];
endmodule

// File: rtl/harris_frame_ctrl.sv
// harris_frame_ctrl: raster sequencer for the Harris pipeline (enable, centre coords, border, frame done).
// Optional corner counter built when HARRIS_CORNER_CNT_EN is defined.
module harris_frame_ctrl import harris_pkg::*; #(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    harris_frame_ctrl_if.slave bus
);
    localparam int FW = $clog2(PIPE_LAT + 1);
    state_t           state;
    logic [CNT_W-1:0] col, row;
    logic [FW-1:0]    flush_cnt;
    logic             accept, last_col, last_row, win_valid, win_border;
    logic [CNT_W-1:0] cx, cy;

    assign bus.pix_ready  = state == S_RUN;
    assign bus.pipe_en    = bus.pix_valid & bus.pix_ready;
    assign bus.busy       = state != S_IDLE;
    assign bus.frame_done = state == S_DONE;
    assign accept   = bus.pipe_en;
    assign last_col = col == CNT_W'(IMG_W - 1);
    assign last_row = row == CNT_W'(IMG_H - 1);
    // The accepted pixel closes the 3x3 window whose centre is one up and one left.
    assign cx = col - CNT_W'(1);
    assign cy = row - CNT_W'(1);
    assign win_valid  = accept && col >= CNT_W'(2) && row >= CNT_W'(2);
    assign win_border = cx == CNT_W'(1) || cx == CNT_W'(IMG_W - 2) ||
                        cy == CNT_W'(1) || cy == CNT_W'(IMG_H - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state <= S_RUN;
                    col   <= '0;
                    row   <= '0;
                end
                S_RUN: if (accept) begin
                    col <= last_col ? '0 : col + CNT_W'(1);
                    if (last_col) row <= last_row ? '0 : row + CNT_W'(1);
                    if (last_col && last_row) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FW'(PIPE_LAT);
                    end
                end
                // Leaves after PIPE_LAT cycles so frame_done lands right after the last out_valid.
                S_FLUSH: if (flush_cnt == FW'(1)) state <= S_DONE;
                         else flush_cnt <= flush_cnt - FW'(1);
                default: state <= S_IDLE;
            endcase
        end
    end

    harris_valid_delay #(.LAT(PIPE_LAT), .CNT_W(CNT_W)) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (win_valid),
        .in_x       (cx),
        .in_y       (cy),
        .in_border  (win_border),
        .out_valid  (bus.out_valid),
        .out_x      (bus.out_x),
        .out_y      (bus.out_y),
        .out_border (bus.border)
    );

`ifdef HARRIS_CORNER_CNT_EN
    logic [7:0]      thr;
    logic [CC_W-1:0] cc, cc_q, cc_nx;
    logic            hit;
    assign hit   = bus.out_valid & ~bus.border & (bus.harris_in >= thr);
    assign cc_nx = cc + CC_W'(hit && !(&cc));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr  <= '0;
            cc   <= '0;
            cc_q <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                thr <= bus.thresh;
                cc  <= '0;
            end else begin
                cc <= cc_nx;
            end
            if (state == S_DONE) cc_q <= cc_nx;
        end
    end
    assign bus.corner_count = cc_q;
`else
    logic unused_score;
    assign unused_score     = ^{bus.harris_in, bus.thresh};
    assign bus.corner_count = '0;
`endif
endmodule

// File: doc/harris_frame_ctrl.md
Name: harris_frame_ctrl

Overview:
- Raster-scan sequencer for the Harris corner pipeline (3-row line buffers -> Sobel -> squared-gradient Gaussian -> cornerness).
- Accepts a pixel stream and generates the pipeline enable, window-centre coordinates, border mask, aligned output-valid and frame completion.
- Sits between the camera/stream source and the Harris datapath; the datapath has fixed, non-stalling latency PIPE_LAT.

Parameters:
- IMG_W, 640, pixels per line (>=4)
- IMG_H, 480, lines per frame (>=4)
- PIPE_LAT, 3, cycles from pipe_en to a valid datapath score (>=1)
- CNT_W, 10, width of the x/y counters; must satisfy 2^CNT_W > max(IMG_W, IMG_H)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a frame when in IDLE
- pix_valid  in  1  source has a pixel this cycle
- pix_ready  out  1  controller accepts the pixel this cycle
- pipe_en  out  1  clock enable to the line buffers and filters; equals pix_valid & pix_ready
- harris_in  in  8  datapath score, aligned with out_valid
- thresh  in  8  corner threshold; sampled at start
- out_valid  out  1  harris_in corresponds to a real window centre
- out_x  out  CNT_W  centre column of the current output
- out_y  out  CNT_W  centre row of the current output
- border  out  1  centre lies on the outer ring of valid centres
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- corner_count  out  20  corners counted in the last frame (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, delay lines cleared. Reset mid-frame aborts the frame; no frame_done is issued.
- States:
  - IDLE: pix_ready=0. start -> RUN, with col=row=0 and thresh latched.
  - RUN: pix_ready=1. On each accept, col++. When col wraps from IMG_W-1 to 0, row++. Accepting pixel (IMG_W-1, IMG_H-1) -> FLUSH.
  - FLUSH: pix_ready=0. A down-counter loads PIPE_LAT and decrements each cycle; at 0 -> DONE.
  - DONE: frame_done=1 for one cycle, corner_count updated, then -> IDLE.
- start outside IDLE is ignored. Gaps in pix_valid during RUN stall the counters only; the delay lines keep shifting.
- Window validity: an accept at (col, row) with col>=2 and row>=2 completes a 3x3 window centred at (col-1, row-1).
- Delay lines: a PIPE_LAT-deep shift register carries {valid, x, y, border} and shifts every cycle. out_* appear exactly PIPE_LAT cycles after the accepting cycle.
- border=1 when the centre has x==1, x==IMG_W-2, y==1 or y==IMG_H-2. These are the positions where the cascaded second 3x3 lacks full support.
- Outputs per frame: out_valid pulses exactly (IMG_W-2)*(IMG_H-2) times.
- Frame end: the last out_valid occurs PIPE_LAT cycles after the last accept, and frame_done follows on the next cycle.
- When out_valid=0, out_x, out_y and border hold their last values.

Optional Feature:
- Macro: HARRIS_CORNER_CNT_EN
- Defined: a 20-bit counter clears on start and increments when out_valid & ~border & (harris_in >= latched thresh). On frame_done, corner_count takes the value including any hit in that same cycle. The counter saturates at 2^20-1.
- Undefined: corner_count is tied to 0, harris_in and thresh are unused, and no counter logic is built.

Decomposition:
- Shared package harris_pkg: state encoding (IDLE, RUN, FLUSH, DONE), default IMG_W/IMG_H/PIPE_LAT, CNT_W derivation constant, corner-count width of 20.
- One sub-module, harris_valid_delay: a parameterised PIPE_LAT-deep shift register for {valid, x, y, border} with asynchronous reset.

Test Plan (IMG_W=8, IMG_H=6, PIPE_LAT=3):
- Continuous pix_valid, single start -> 48 accepts, 24 out_valid pulses, first at centre (1,1), last at (6,4). frame_done one cycle after the last out_valid. busy returns to 0.
- Border check on the same frame -> exactly 8 out_valid with border=0, covering x in 2..5 and y in 2..3.
- pix_valid toggling 1,0,1,0 -> still 24 outputs with the same coordinates. Each out_valid occurs exactly 3 cycles after its accept.
- start pulsed again mid-RUN -> ignored, counters unaffected. rst_n low mid-RUN -> all outputs 0 next cycle, no frame_done. A subsequent start produces a clean frame.
- HARRIS_CORNER_CNT_EN defined, thresh=100, harris_in=120 on 3 interior centres, 50 elsewhere, 255 on one border centre -> corner_count=3 at frame_done.
- HARRIS_CORNER_CNT_EN undefined, same stimulus -> corner_count=0 throughout.
